// File: rtl/ibus_dbus_arbiter_pkg.sv
// ibus_dbus_arbiter_pkg
// Shared definitions for the ibus/dbus arbiter slice: FSM state encodings,
// master identifiers, the fixed byte-lane pattern used for instruction
// fetches, and small helpers for the round-robin choice and the timeout
// counter width.
// No ports (package).

package ibus_dbus_arbiter_pkg;

    // Arbiter FSM states: waiting for a request, or holding a grant for one master.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_e;

    // Master identifiers, also used as the round-robin "last granted" pointer.
    typedef enum logic {
        MASTER_I = 1'b0,
        MASTER_D = 1'b1
    } master_id_e;

    // Fetches always read a full word.
    localparam logic [3:0] IBUS_DEFAULT_SEL = 4'hF;

    // Default number of granted cycles without a slave response before the
    // transaction is forced to complete.
    localparam int unsigned DEFAULT_TIMEOUT_CYC = 16;

    // Picks the winner among the pending requests. Only meaningful when at
    // least one request is pending; on a conflict the master that did not
    // win last time gets the bus.
    function automatic master_id_e rr_pick(input logic       ibus_req,
                                           input logic       dbus_req,
                                           input master_id_e last_gnt);
        master_id_e winner;
        if (ibus_req && dbus_req) begin
            winner = (last_gnt == MASTER_I) ? MASTER_D : MASTER_I;
        end else if (dbus_req) begin
            winner = MASTER_D;
        end else begin
            winner = MASTER_I;
        end
        return winner;
    endfunction

    // Width of the timeout counter; at least one bit so a disabled timeout
    // still yields a legal vector.
    function automatic int unsigned timeout_cnt_width(input int unsigned timeout_cyc);
        return (timeout_cyc == 0) ? 1 : $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/ibus_dbus_arbiter_if.sv
// ibus_dbus_arbiter_if
// Bundles the three bus sides seen by the arbiter: the core's fetch port
// (ibus), the core's load/store port (dbus) and the shared memory bus.
// Signal names are written from the arbiter's point of view (i_* enter the
// arbiter, o_* leave it).
//   modport slave  : the arbiter itself
//   modport master : the environment around it (core ports and memory)

interface ibus_dbus_arbiter_if;

    // Fetch port
    logic [31:0] i_ibus_addr;
    logic        i_ibus_req;
    logic [31:0] o_ibus_data;
    logic        o_ibus_rsp;

    // Load/store port
    logic [31:0] i_dbus_addr;
    logic [31:0] i_dbus_wdata;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_req;
    logic [31:0] o_dbus_rdata;
    logic        o_dbus_rsp;

    // Shared memory bus
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_sel;
    logic        o_bus_we;
    logic        o_bus_req;
    logic [31:0] i_bus_rdata;
    logic        i_bus_rsp;
    logic        o_bus_err;

    modport slave (
        input  i_ibus_addr, i_ibus_req,
        output o_ibus_data, o_ibus_rsp,
        input  i_dbus_addr, i_dbus_wdata, i_dbus_sel, i_dbus_we, i_dbus_req,
        output o_dbus_rdata, o_dbus_rsp,
        output o_bus_addr, o_bus_wdata, o_bus_sel, o_bus_we, o_bus_req,
        input  i_bus_rdata, i_bus_rsp,
        output o_bus_err
    );

    modport master (
        output i_ibus_addr, i_ibus_req,
        input  o_ibus_data, o_ibus_rsp,
        output i_dbus_addr, i_dbus_wdata, i_dbus_sel, i_dbus_we, i_dbus_req,
        input  o_dbus_rdata, o_dbus_rsp,
        input  o_bus_addr, o_bus_wdata, o_bus_sel, o_bus_we, o_bus_req,
        output i_bus_rdata, i_bus_rsp,
        input  o_bus_err
    );

endinterface

// File: rtl/ibus_dbus_arbiter_timeout_cnt.sv
// bus_timeout_cnt
// Counts granted cycles that pass without a slave response and flags the
// cycle in which the transaction must be forced to complete.
// Ports:
//   clk     in  clock
//   rst_n   in  asynchronous active-low reset
//   clear   in  restart counting (asserted on the grant edge)
//   enable  in  a granted cycle with no slave response
//   expire  out this enabled cycle is the last one allowed (TIMEOUT_CYC-th)
// TIMEOUT_CYC = 0 disables expiry entirely.

module bus_timeout_cnt
    import ibus_dbus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = timeout_cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LIMIT =
        (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count stops at LIMIT rather than wrapping, so a long stall can never
    // alias back to an early count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (TIMEOUT_CYC != 0) && enable && (cnt_q == LIMIT);

endmodule

// File: rtl/ibus_dbus_arbiter.sv
// ibus_dbus_arbiter
// Merges the core's fetch (ibus) and load/store (dbus) ports onto a single
// memory bus. Conflicts are resolved round-robin, one transaction is in
// flight at a time, and a stalled slave is cut off after TIMEOUT_CYC granted
// cycles with an error pulse.
// Ports:
//   i_clk    in  clock
//   i_rst_n  in  asynchronous active-low reset
//   arb_if   ibus_dbus_arbiter_if.slave: fetch port, load/store port and
//            shared memory bus (request fields registered on grant,
//            responses passed through combinationally)

module ibus_dbus_arbiter
    import ibus_dbus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    ibus_dbus_arbiter_if.slave        arb_if
);

    arb_state_e  state_q,     state_d;
    master_id_e  last_gnt_q,  last_gnt_d;
    logic [31:0] bus_addr_q,  bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_sel_q,   bus_sel_d;
    logic        bus_we_q,    bus_we_d;
    logic        bus_req_q,   bus_req_d;

    logic        any_req;
    master_id_e  winner;
    logic        timeout_clear;
    logic        timeout_enable;
    logic        timeout_expire;

    logic        ibus_rsp;
    logic [31:0] ibus_data;
    logic        dbus_rsp;
    logic [31:0] dbus_rdata;
    logic        bus_err;

    assign any_req = arb_if.i_ibus_req || arb_if.i_dbus_req;
    assign winner  = rr_pick(arb_if.i_ibus_req, arb_if.i_dbus_req, last_gnt_q);

    // Timeout control lives outside the FSM process so the expire path has
    // no combinational feedback through it.
    assign timeout_clear  = (state_q == ST_IDLE) && any_req;
    assign timeout_enable = (state_q != ST_IDLE) && !arb_if.i_bus_rsp;

    bus_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clear  (timeout_clear),
        .enable (timeout_enable),
        .expire (timeout_expire)
    );

    // Next-state and response demux. Requests are sampled only in IDLE, so
    // a request still high in the completing cycle waits for the single
    // IDLE cycle. A timed-out transaction returns zero data, not whatever
    // the slave happens to drive.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        bus_we_d    = bus_we_q;
        bus_req_d   = bus_req_q;
        ibus_rsp    = 1'b0;
        ibus_data   = '0;
        dbus_rsp    = 1'b0;
        dbus_rdata  = '0;
        bus_err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    bus_req_d  = 1'b1;
                    last_gnt_d = winner;
                    if (winner == MASTER_D) begin
                        bus_addr_d  = arb_if.i_dbus_addr;
                        bus_wdata_d = arb_if.i_dbus_wdata;
                        bus_sel_d   = arb_if.i_dbus_sel;
                        bus_we_d    = arb_if.i_dbus_we;
                        state_d     = ST_GNT_D;
                    end else begin
                        bus_addr_d  = arb_if.i_ibus_addr;
                        bus_wdata_d = '0;
                        bus_sel_d   = IBUS_DEFAULT_SEL;
                        bus_we_d    = 1'b0;
                        state_d     = ST_GNT_I;
                    end
                end
            end

            ST_GNT_I: begin
                ibus_rsp  = arb_if.i_bus_rsp || timeout_expire;
                ibus_data = timeout_expire ? 32'h0 : arb_if.i_bus_rdata;
                bus_err   = timeout_expire;
                if (arb_if.i_bus_rsp || timeout_expire) begin
                    bus_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            ST_GNT_D: begin
                dbus_rsp   = arb_if.i_bus_rsp || timeout_expire;
                dbus_rdata = timeout_expire ? 32'h0 : arb_if.i_bus_rdata;
                bus_err    = timeout_expire;
                if (arb_if.i_bus_rsp || timeout_expire) begin
                    bus_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                bus_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State, round-robin pointer and registered bus request fields. The
    // pointer starts at ibus so the first conflict goes to dbus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= MASTER_I;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            bus_we_q    <= 1'b0;
            bus_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            bus_we_q    <= bus_we_d;
            bus_req_q   <= bus_req_d;
        end
    end

    assign arb_if.o_bus_addr   = bus_addr_q;
    assign arb_if.o_bus_wdata  = bus_wdata_q;
    assign arb_if.o_bus_sel    = bus_sel_q;
    assign arb_if.o_bus_we     = bus_we_q;
    assign arb_if.o_bus_req    = bus_req_q;
    assign arb_if.o_bus_err    = bus_err;
    assign arb_if.o_ibus_rsp   = ibus_rsp;
    assign arb_if.o_ibus_data  = ibus_data;
    assign arb_if.o_dbus_rsp   = dbus_rsp;
    assign arb_if.o_dbus_rdata = dbus_rdata;

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// tb_ibus_dbus_arbiter
// Directed bench for ibus_dbus_arbiter with TIMEOUT_CYC = 16. Inputs change
// 1 ns after the rising edge, outputs are sampled a few ns later, inside the
// same cycle, so combinational responses are seen settled.

module tb_ibus_dbus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ibus_dbus_arbiter_if arb_if ();

    ibus_dbus_arbiter #(
        .TIMEOUT_CYC (16)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .arb_if  (arb_if)
    );

    always #5 clk = ~clk;

    // Drive every arbiter input to its quiet value.
    task automatic idle_inputs();
        arb_if.i_ibus_addr  = '0;
        arb_if.i_ibus_req   = 1'b0;
        arb_if.i_dbus_addr  = '0;
        arb_if.i_dbus_wdata = '0;
        arb_if.i_dbus_sel   = '0;
        arb_if.i_dbus_we    = 1'b0;
        arb_if.i_dbus_req   = 1'b0;
        arb_if.i_bus_rdata  = '0;
        arb_if.i_bus_rsp    = 1'b0;
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        arb_if.i_bus_rsp = 1'b1;
        #12;
        checks++;
        if (arb_if.o_bus_req !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_bus_req: got %b expected 0", arb_if.o_bus_req);
        end
        checks++;
        if (arb_if.o_bus_addr !== 32'h0 || arb_if.o_bus_wdata !== 32'h0 ||
            arb_if.o_bus_sel !== 4'h0 || arb_if.o_bus_we !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_bus_fields: got addr=%h wdata=%h sel=%h we=%b expected all 0",
                               arb_if.o_bus_addr, arb_if.o_bus_wdata, arb_if.o_bus_sel, arb_if.o_bus_we);
        end
        checks++;
        if (arb_if.o_ibus_rsp !== 1'b0 || arb_if.o_dbus_rsp !== 1'b0 || arb_if.o_bus_err !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_rsp: got ibus=%b dbus=%b err=%b expected 0 0 0",
                               arb_if.o_ibus_rsp, arb_if.o_dbus_rsp, arb_if.o_bus_err);
        end
        arb_if.i_bus_rsp = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_ibus_only();
        arb_if.i_ibus_addr = 32'h100;
        arb_if.i_ibus_req  = 1'b1;
        next_cycle();
        #2;
        checks++;
        if (arb_if.o_bus_req !== 1'b1 || arb_if.o_bus_addr !== 32'h100) begin
            errors++; $display("[TB] FAIL ibus_grant: got req=%b addr=%h expected 1 00000100",
                               arb_if.o_bus_req, arb_if.o_bus_addr);
        end
        checks++;
        if (arb_if.o_bus_sel !== 4'hF || arb_if.o_bus_we !== 1'b0 || arb_if.o_bus_wdata !== 32'h0) begin
            errors++; $display("[TB] FAIL ibus_fields: got sel=%h we=%b wdata=%h expected f 0 00000000",
                               arb_if.o_bus_sel, arb_if.o_bus_we, arb_if.o_bus_wdata);
        end
        checks++;
        if (arb_if.o_ibus_rsp !== 1'b0) begin
            errors++; $display("[TB] FAIL ibus_early_rsp: got %b expected 0", arb_if.o_ibus_rsp);
        end
        next_cycle();
        arb_if.i_bus_rsp   = 1'b1;
        arb_if.i_bus_rdata = 32'h0000_0013;
        #2;
        checks++;
        if (arb_if.o_ibus_rsp !== 1'b1 || arb_if.o_ibus_data !== 32'h13 || arb_if.o_dbus_rsp !== 1'b0) begin
            errors++; $display("[TB] FAIL ibus_rsp: got rsp=%b data=%h dbus_rsp=%b expected 1 00000013 0",
                               arb_if.o_ibus_rsp, arb_if.o_ibus_data, arb_if.o_dbus_rsp);
        end
        next_cycle();
        idle_inputs();
        #2;
        checks++;
        if (arb_if.o_bus_req !== 1'b0 || arb_if.o_bus_addr !== 32'h100) begin
            errors++; $display("[TB] FAIL ibus_done: got req=%b addr=%h expected 0 00000100",
                               arb_if.o_bus_req, arb_if.o_bus_addr);
        end
    endtask

    task automatic test_round_robin();
        logic exp_d;
        logic [31:0] exp_addr;
        do_reset();
        arb_if.i_ibus_addr = 32'h1000;
        arb_if.i_dbus_addr = 32'h3000;
        arb_if.i_dbus_sel  = 4'h3;
        arb_if.i_ibus_req  = 1'b1;
        arb_if.i_dbus_req  = 1'b1;
        for (int r = 0; r < 8; r++) begin
            exp_d    = (r % 2 == 0);
            exp_addr = exp_d ? 32'h3000 : 32'h1000;
            next_cycle();
            #2;
            checks++;
            if (arb_if.o_bus_req !== 1'b1 || arb_if.o_bus_addr !== exp_addr) begin
                errors++; $display("[TB] FAIL rr_winner round %0d: got req=%b addr=%h expected 1 %h",
                                   r, arb_if.o_bus_req, arb_if.o_bus_addr, exp_addr);
            end
            arb_if.i_bus_rsp   = 1'b1;
            arb_if.i_bus_rdata = 32'hA000_0000 + 32'(r);
            #1;
            checks++;
            if (arb_if.o_dbus_rsp !== exp_d || arb_if.o_ibus_rsp !== !exp_d) begin
                errors++; $display("[TB] FAIL rr_rsp round %0d: got ibus=%b dbus=%b expected %b %b",
                                   r, arb_if.o_ibus_rsp, arb_if.o_dbus_rsp, !exp_d, exp_d);
            end
            next_cycle();
            arb_if.i_bus_rsp = 1'b0;
            #2;
            checks++;
            if (arb_if.o_bus_req !== 1'b0) begin
                errors++; $display("[TB] FAIL rr_idle_gap round %0d: got req=%b expected 0", r, arb_if.o_bus_req);
            end
        end
        idle_inputs();
    endtask

    task automatic test_dbus_store();
        arb_if.i_dbus_addr  = 32'h2000;
        arb_if.i_dbus_wdata = 32'hCAFE_BABE;
        arb_if.i_dbus_sel   = 4'b0011;
        arb_if.i_dbus_we    = 1'b1;
        arb_if.i_dbus_req   = 1'b1;
        next_cycle();
        #2;
        checks++;
        if (arb_if.o_bus_addr !== 32'h2000 || arb_if.o_bus_wdata !== 32'hCAFE_BABE ||
            arb_if.o_bus_sel !== 4'b0011 || arb_if.o_bus_we !== 1'b1 || arb_if.o_bus_req !== 1'b1) begin
            errors++; $display("[TB] FAIL store_fields: got addr=%h wdata=%h sel=%h we=%b req=%b expected 00002000 cafebabe 3 1 1",
                               arb_if.o_bus_addr, arb_if.o_bus_wdata, arb_if.o_bus_sel, arb_if.o_bus_we, arb_if.o_bus_req);
        end
        arb_if.i_bus_rsp = 1'b1;
        #1;
        checks++;
        if (arb_if.o_dbus_rsp !== 1'b1 || arb_if.o_ibus_rsp !== 1'b0) begin
            errors++; $display("[TB] FAIL store_rsp: got dbus=%b ibus=%b expected 1 0",
                               arb_if.o_dbus_rsp, arb_if.o_ibus_rsp);
        end
        next_cycle();
        idle_inputs();
        #2;
        checks++;
        if (arb_if.o_bus_req !== 1'b0 || arb_if.o_bus_we !== 1'b1) begin
            errors++; $display("[TB] FAIL store_done: got req=%b we=%b expected 0 1",
                               arb_if.o_bus_req, arb_if.o_bus_we);
        end
    endtask

    task automatic test_req_drop();
        arb_if.i_ibus_addr = 32'h180;
        arb_if.i_ibus_req  = 1'b1;
        next_cycle();
        arb_if.i_ibus_req  = 1'b0;
        next_cycle();
        arb_if.i_bus_rsp   = 1'b1;
        arb_if.i_bus_rdata = 32'h1234_5678;
        #2;
        checks++;
        if (arb_if.o_ibus_rsp !== 1'b1 || arb_if.o_ibus_data !== 32'h1234_5678) begin
            errors++; $display("[TB] FAIL drop_rsp: got rsp=%b data=%h expected 1 12345678",
                               arb_if.o_ibus_rsp, arb_if.o_ibus_data);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_timeout(input logic rsp_at_expiry);
        logic early;
        early = 1'b0;
        arb_if.i_dbus_addr = 32'h4000;
        arb_if.i_dbus_sel  = 4'hF;
        arb_if.i_dbus_we   = 1'b0;
        arb_if.i_dbus_req  = 1'b1;
        arb_if.i_bus_rdata = 32'hDEAD_BEEF;
        next_cycle();
        for (int k = 1; k <= 15; k++) begin
            #2;
            if (arb_if.o_dbus_rsp !== 1'b0 || arb_if.o_bus_err !== 1'b0 || arb_if.o_bus_req !== 1'b1) early = 1'b1;
            next_cycle();
        end
        checks++;
        if (early !== 1'b0) begin
            errors++; $display("[TB] FAIL timeout_early: got early completion %b expected 0", early);
        end
        if (rsp_at_expiry) begin
            arb_if.i_bus_rsp   = 1'b1;
            arb_if.i_bus_rdata = 32'h55AA_55AA;
        end
        #2;
        checks++;
        if (rsp_at_expiry) begin
            if (arb_if.o_dbus_rsp !== 1'b1 || arb_if.o_bus_err !== 1'b0 || arb_if.o_dbus_rdata !== 32'h55AA_55AA) begin
                errors++; $display("[TB] FAIL expiry_rsp_wins: got rsp=%b err=%b rdata=%h expected 1 0 55aa55aa",
                                   arb_if.o_dbus_rsp, arb_if.o_bus_err, arb_if.o_dbus_rdata);
            end
        end else begin
            if (arb_if.o_dbus_rsp !== 1'b1 || arb_if.o_bus_err !== 1'b1 || arb_if.o_dbus_rdata !== 32'h0) begin
                errors++; $display("[TB] FAIL timeout_pulse: got rsp=%b err=%b rdata=%h expected 1 1 00000000",
                                   arb_if.o_dbus_rsp, arb_if.o_bus_err, arb_if.o_dbus_rdata);
            end
        end
        checks++;
        if (arb_if.o_ibus_rsp !== 1'b0) begin
            errors++; $display("[TB] FAIL timeout_ibus_quiet: got %b expected 0", arb_if.o_ibus_rsp);
        end
        next_cycle();
        arb_if.i_dbus_req = 1'b0;
        arb_if.i_bus_rsp  = rsp_at_expiry;
        #2;
        checks++;
        if (arb_if.o_bus_req !== 1'b0 || arb_if.o_bus_err !== 1'b0 ||
            arb_if.o_dbus_rsp !== 1'b0 || arb_if.o_ibus_rsp !== 1'b0) begin
            errors++; $display("[TB] FAIL post_timeout_idle: got req=%b err=%b dbus=%b ibus=%b expected 0 0 0 0",
                               arb_if.o_bus_req, arb_if.o_bus_err, arb_if.o_dbus_rsp, arb_if.o_ibus_rsp);
        end
        next_cycle();
        idle_inputs();
        #2;
        checks++;
        if (arb_if.o_bus_req !== 1'b0) begin
            errors++; $display("[TB] FAIL stray_no_grant: got req=%b expected 0", arb_if.o_bus_req);
        end
    endtask

    task automatic test_reset_mid_txn();
        arb_if.i_dbus_addr = 32'h5000;
        arb_if.i_dbus_req  = 1'b1;
        next_cycle();
        #2;
        checks++;
        if (arb_if.o_bus_req !== 1'b1) begin
            errors++; $display("[TB] FAIL midrst_grant: got req=%b expected 1", arb_if.o_bus_req);
        end
        rst_n = 1'b0;
        arb_if.i_bus_rsp = 1'b1;
        #1;
        checks++;
        if (arb_if.o_bus_req !== 1'b0 || arb_if.o_dbus_rsp !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_abort: got req=%b dbus_rsp=%b expected 0 0",
                               arb_if.o_bus_req, arb_if.o_dbus_rsp);
        end
        arb_if.i_dbus_req = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        #2;
        checks++;
        if (arb_if.o_dbus_rsp !== 1'b0 || arb_if.o_ibus_rsp !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_inflight: got dbus=%b ibus=%b expected 0 0",
                               arb_if.o_dbus_rsp, arb_if.o_ibus_rsp);
        end
        next_cycle();
        arb_if.i_bus_rsp   = 1'b0;
        arb_if.i_ibus_addr = 32'h200;
        arb_if.i_ibus_req  = 1'b1;
        next_cycle();
        #2;
        checks++;
        if (arb_if.o_bus_req !== 1'b1 || arb_if.o_bus_addr !== 32'h200 || arb_if.o_bus_sel !== 4'hF) begin
            errors++; $display("[TB] FAIL midrst_ibus_grant: got req=%b addr=%h sel=%h expected 1 00000200 f",
                               arb_if.o_bus_req, arb_if.o_bus_addr, arb_if.o_bus_sel);
        end
        arb_if.i_bus_rsp   = 1'b1;
        arb_if.i_bus_rdata = 32'h33;
        #1;
        checks++;
        if (arb_if.o_ibus_rsp !== 1'b1 || arb_if.o_ibus_data !== 32'h33) begin
            errors++; $display("[TB] FAIL midrst_ibus_rsp: got rsp=%b data=%h expected 1 00000033",
                               arb_if.o_ibus_rsp, arb_if.o_ibus_data);
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_ibus_only();
        test_round_robin();
        test_dbus_store();
        test_req_drop();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid_txn();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
